// File: rtl/rom_prefetch_buffer.sv
// Sequential instruction prefetch in front of a 1-cycle-latency ROM.
// Returned words and their addresses queue in a small FIFO; redirect flushes and restarts fetch.
module rom_prefetch_buffer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [ADDR_W-1:0]         rom_address,
  output logic                      rom_chipselect,
  output logic                      rom_clken,
  input  logic [DATA_W-1:0]         rom_readdata,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_addr,
  output logic                      ins_valid,
  output logic [DATA_W-1:0]         ins_data,
  output logic [ADDR_W-1:0]         ins_addr,
  input  logic                      ins_ready,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] RST_A   = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              pend_kill_q, pend_kill_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [CW:0] credits;
  logic        head_vld, issue, push, pop;

  // The in-flight read holds a credit so a full FIFO can never be overrun by a late return.
  assign credits  = {1'b0, count_q} + {{CW{1'b0}}, rd_pend_q};
  assign head_vld = (count_q != '0);
  assign issue    = !reset && !redirect_valid && (credits < DEPTH_C);
  assign push     = !reset && !redirect_valid && rd_pend_q && !pend_kill_q;
  assign pop      = !reset && !redirect_valid && head_vld && ins_ready;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    rd_pend_d    = issue;
    pend_kill_d  = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_data_d   = mem_data_q;
    mem_addr_d   = mem_addr_q;

    if (issue) begin
      pend_addr_d  = fetch_addr_q;
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end

    if (push) begin
      mem_data_d[wr_ptr_q] = rom_readdata;
      mem_addr_d[wr_ptr_q] = pend_addr_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      fetch_addr_d = redirect_addr;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pend_kill_d  = rd_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q <= RST_A;
      pend_addr_q  <= '0;
      rd_pend_q    <= 1'b0;
      pend_kill_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_data_q   <= '0;
      mem_addr_q   <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      rd_pend_q    <= rd_pend_d;
      pend_kill_q  <= pend_kill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_data_q   <= mem_data_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Outputs are forced to their idle values while reset is asserted, even on the first reset cycle.
  assign rom_address    = reset ? RST_A : fetch_addr_q;
  assign rom_chipselect = issue;
  assign rom_clken      = 1'b1;
  assign ins_valid      = !reset && head_vld;
  assign ins_data       = reset ? '0 : mem_data_q[rd_ptr_q];
  assign ins_addr       = reset ? '0 : mem_addr_q[rd_ptr_q];
  assign fill_level     = reset ? '0 : count_q;

endmodule

// File: tb/tb_rom_prefetch_buffer.sv
// Directed bench: per-cycle vector table for streaming/stall/redirect/reset,
// plus a hand-written stall-and-release sequence from a fresh reset.
module tb_rom_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rom_address;
  logic        rom_chipselect;
  logic        rom_clken;
  logic [31:0] rom_readdata;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [9:0]  ins_addr;
  logic        ins_ready;
  logic [2:0]  fill_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rom_prefetch_buffer #(.ADDR_W(10), .DATA_W(32), .DEPTH(4), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_clken(rom_clken),
    .rom_readdata(rom_readdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_addr(ins_addr),
    .ins_ready(ins_ready), .fill_level(fill_level)
  );

  // ROM model: word k = 0xA000_0000 + k one cycle after the read; junk when no read issued.
  always @(posedge clk)
    rom_readdata <= rom_chipselect ? (32'hA000_0000 + 32'(rom_address)) : 32'hDEAD_BEEF;

  typedef struct {
    logic       rst;
    logic       rv;
    logic [9:0] ra;
    logic       rdy;
    logic       cs;
    logic [9:0] addr;
    logic       iv;
    logic [9:0] ia;
    logic [2:0] fill;
  } vec_t;

  localparam int NV = 40;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic rv, input logic [9:0] ra, input logic rdy,
                              input logic cs, input logic [9:0] addr, input logic iv,
                              input logic [9:0] ia, input logic [2:0] fill);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.cs = cs; v.addr = addr; v.iv = iv; v.ia = ia; v.fill = fill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n_iss, got, gaps, expa;
    logic stable;

    //                rst rv  ra      rdy  cs  addr    iv  ia      fill
    vecs[0]  = mk(1, 0, 10'h000, 1,  0, 10'h000, 0, 10'h000, 0);
    vecs[1]  = mk(1, 0, 10'h000, 1,  0, 10'h000, 0, 10'h000, 0);
    vecs[2]  = mk(0, 0, 10'h000, 1,  1, 10'h000, 0, 10'h000, 0);
    vecs[3]  = mk(0, 0, 10'h000, 1,  1, 10'h001, 0, 10'h000, 0);
    vecs[4]  = mk(0, 0, 10'h000, 1,  1, 10'h002, 1, 10'h000, 1);
    vecs[5]  = mk(0, 0, 10'h000, 1,  1, 10'h003, 1, 10'h001, 1);
    vecs[6]  = mk(0, 0, 10'h000, 1,  1, 10'h004, 1, 10'h002, 1);
    vecs[7]  = mk(0, 0, 10'h000, 0,  1, 10'h005, 1, 10'h003, 1);
    vecs[8]  = mk(0, 0, 10'h000, 0,  1, 10'h006, 1, 10'h003, 2);
    vecs[9]  = mk(0, 0, 10'h000, 0,  0, 10'h007, 1, 10'h003, 3);
    vecs[10] = mk(0, 0, 10'h000, 0,  0, 10'h007, 1, 10'h003, 4);
    vecs[11] = mk(0, 0, 10'h000, 0,  0, 10'h007, 1, 10'h003, 4);
    vecs[12] = mk(0, 0, 10'h000, 1,  0, 10'h007, 1, 10'h003, 4);
    vecs[13] = mk(0, 0, 10'h000, 1,  1, 10'h007, 1, 10'h004, 3);
    vecs[14] = mk(0, 0, 10'h000, 1,  1, 10'h008, 1, 10'h005, 2);
    vecs[15] = mk(0, 0, 10'h000, 1,  1, 10'h009, 1, 10'h006, 2);
    vecs[16] = mk(0, 0, 10'h000, 1,  1, 10'h00A, 1, 10'h007, 2);
    vecs[17] = mk(0, 1, 10'h200, 1,  0, 10'h00B, 1, 10'h008, 2);
    vecs[18] = mk(0, 0, 10'h000, 1,  1, 10'h200, 0, 10'h000, 0);
    vecs[19] = mk(0, 0, 10'h000, 1,  1, 10'h201, 0, 10'h000, 0);
    vecs[20] = mk(0, 0, 10'h000, 1,  1, 10'h202, 1, 10'h200, 1);
    vecs[21] = mk(0, 0, 10'h000, 1,  1, 10'h203, 1, 10'h201, 1);
    vecs[22] = mk(0, 1, 10'h3FE, 1,  0, 10'h204, 1, 10'h202, 1);
    vecs[23] = mk(0, 0, 10'h000, 1,  1, 10'h3FE, 0, 10'h000, 0);
    vecs[24] = mk(0, 0, 10'h000, 1,  1, 10'h3FF, 0, 10'h000, 0);
    vecs[25] = mk(0, 0, 10'h000, 1,  1, 10'h000, 1, 10'h3FE, 1);
    vecs[26] = mk(0, 0, 10'h000, 1,  1, 10'h001, 1, 10'h3FF, 1);
    vecs[27] = mk(0, 0, 10'h000, 1,  1, 10'h002, 1, 10'h000, 1);
    vecs[28] = mk(0, 0, 10'h000, 1,  1, 10'h003, 1, 10'h001, 1);
    vecs[29] = mk(0, 1, 10'h010, 1,  0, 10'h004, 1, 10'h002, 1);
    vecs[30] = mk(0, 1, 10'h020, 1,  0, 10'h010, 0, 10'h000, 0);
    vecs[31] = mk(0, 0, 10'h000, 1,  1, 10'h020, 0, 10'h000, 0);
    vecs[32] = mk(0, 0, 10'h000, 1,  1, 10'h021, 0, 10'h000, 0);
    vecs[33] = mk(0, 0, 10'h000, 1,  1, 10'h022, 1, 10'h020, 1);
    vecs[34] = mk(0, 0, 10'h000, 1,  1, 10'h023, 1, 10'h021, 1);
    vecs[35] = mk(1, 0, 10'h000, 1,  0, 10'h000, 0, 10'h000, 0);
    vecs[36] = mk(0, 0, 10'h000, 1,  1, 10'h000, 0, 10'h000, 0);
    vecs[37] = mk(0, 0, 10'h000, 1,  1, 10'h001, 0, 10'h000, 0);
    vecs[38] = mk(0, 0, 10'h000, 1,  1, 10'h002, 1, 10'h000, 1);
    vecs[39] = mk(0, 0, 10'h000, 1,  1, 10'h003, 1, 10'h001, 1);

    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; ins_ready = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst; redirect_valid = vecs[i].rv;
      redirect_addr = vecs[i].ra; ins_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d.cs", i),    32'(rom_chipselect), 32'(vecs[i].cs));
      chk($sformatf("v%0d.clken", i), 32'(rom_clken),      32'd1);
      chk($sformatf("v%0d.raddr", i), 32'(rom_address),    32'(vecs[i].addr));
      chk($sformatf("v%0d.iv", i),    32'(ins_valid),      32'(vecs[i].iv));
      chk($sformatf("v%0d.fill", i),  32'(fill_level),     32'(vecs[i].fill));
      if (vecs[i].iv || vecs[i].rst) begin
        chk($sformatf("v%0d.iaddr", i), 32'(ins_addr), 32'(vecs[i].ia));
        chk($sformatf("v%0d.idata", i), ins_data,
            vecs[i].rst ? 32'h0 : 32'hA000_0000 + 32'(vecs[i].ia));
      end
    end

    // Stall from a fresh reset: exactly DEPTH issues, head pinned at address 0.
    @(posedge clk); #1;
    reset = 1'b1; redirect_valid = 1'b0; ins_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_iss = 0; stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rom_chipselect) n_iss++;
      if (ins_valid && (ins_addr != 10'h000 || ins_data != 32'hA000_0000)) stable = 1'b0;
    end
    chk("stall.issues", 32'(n_iss), 32'd4);
    chk("stall.fill",   32'(fill_level), 32'd4);
    chk("stall.valid",  32'(ins_valid), 32'd1);
    chk("stall.head",   32'(ins_addr), 32'd0);
    chk("stall.data",   ins_data, 32'hA000_0000);
    chk("stall.stable", 32'(stable), 32'd1);

    // Release: in-order, gap-free delivery of 0..11.
    @(posedge clk); #1;
    ins_ready = 1'b1;
    got = 0; gaps = 0; expa = 0;
    for (int c = 0; c < 40 && got < 12; c++) begin
      @(negedge clk);
      if (ins_valid) begin
        chk($sformatf("rel%0d.addr", got), 32'(ins_addr), 32'(expa));
        chk($sformatf("rel%0d.data", got), ins_data, 32'hA000_0000 + 32'(expa));
        expa++; got++;
      end else begin
        gaps++;
      end
    end
    chk("rel.count", 32'(got), 32'd12);
    chk("rel.gaps",  32'(gaps), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
